// File: rtl/spy_bus_master.sv
// rtl/spy_bus_master.sv - CADR spy/debug bus master: command/response to dbread/dbwrite strobes
//
// Purpose: accepts one command at a time (read or write of a spy register),
// drives registered dbread/dbwrite/eadr/spy_out for STROBE_LEN cycles, samples
// spy_in RD_LAT cycles after the first read strobe cycle, and returns one
// response word per beat. Each beat ends with a one-cycle bus-idle GAP.
//
// Optional feature macro: SPY_BURST_EN. When defined, cmd_len exists and a
// read performs cmd_len+1 beats at consecutive addresses (mod 2^AW).
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake (cmd_ready high only in IDLE)
//   cmd_write/addr/wdata   command fields; cmd_len only with SPY_BURST_EN
//   rsp_valid/rsp_ready    response handshake, response held until accepted
//   rsp_write/last/rdata   response fields
//   spy_in                 read data from the CPU spy register file
//   spy_out, dbread,       registered spy bus outputs, all zero outside
//   dbwrite, eadr          the strobe cycles
module spy_bus_master #(
   parameter int DW         = 16,
   parameter int AW         = 4,
   parameter int STROBE_LEN = 1,
   parameter int RD_LAT     = 1,
   parameter int LW         = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_write,
   input  logic [AW-1:0] cmd_addr,
   input  logic [DW-1:0] cmd_wdata,
`ifdef SPY_BURST_EN
   input  logic [LW-1:0] cmd_len,
`endif
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic          rsp_write,
   output logic          rsp_last,
   output logic [DW-1:0] rsp_rdata,
   input  logic [DW-1:0] spy_in,
   output logic [DW-1:0] spy_out,
   output logic          dbread,
   output logic          dbwrite,
   output logic [AW-1:0] eadr
);

   // Counter spans 1..RD_LAT (RD_LAT >= STROBE_LEN), one spare code for headroom.
   localparam int CW = $clog2(RD_LAT + 2);
   localparam logic [CW-1:0] STROBE_END = CW'(STROBE_LEN);
   localparam logic [CW-1:0] SAMPLE_AT  = CW'(RD_LAT);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      STROBE = 3'd1,
      WAIT   = 3'd2,
      RESP   = 3'd3,
      GAP    = 3'd4
   } state_t;

   state_t        state;
   state_t        next_state;
   logic [CW-1:0] cnt;
   logic          is_write;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [LW-1:0] len_left;
   logic [LW-1:0] len_in;

   logic          accept;
   logic          sample;
   logic          beat_write;
   logic [AW-1:0] beat_addr;
   logic [DW-1:0] beat_wdata;

   logic          nxt_cmd_ready;
   logic          nxt_dbread;
   logic          nxt_dbwrite;
   logic [AW-1:0] nxt_eadr;
   logic [DW-1:0] nxt_spy_out;
   logic          nxt_rsp_valid;
   logic          nxt_rsp_write;
   logic          nxt_rsp_last;
   logic [DW-1:0] nxt_rsp_rdata;

`ifdef SPY_BURST_EN
   assign len_in = cmd_len;
`else
   // Without bursts the remaining-beat count is always zero, so every
   // response is the last one.
   assign len_in = '0;
`endif

   assign accept = cmd_valid && cmd_ready && (state == IDLE);

   // Sample edge for reads; for writes the same edge just raises the ack.
   assign sample = (next_state == RESP) && ((state == STROBE) || (state == WAIT));

   // State register plus the per-command datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         cnt      <= '0;
         is_write <= 1'b0;
         addr     <= '0;
         wdata    <= '0;
         len_left <= '0;
      end else begin
         state <= next_state;
         if (accept) begin
            is_write <= cmd_write;
            wdata    <= cmd_wdata;
            len_left <= cmd_write ? '0 : len_in;
         end else if ((state == GAP) && (next_state == STROBE)) begin
            len_left <= len_left - 1'b1;
         end
         if (next_state == STROBE) begin
            addr <= beat_addr;
         end
         // cnt holds the index (1-based) of the current cycle within the beat.
         if ((next_state == STROBE) && (state != STROBE)) begin
            cnt <= CW'(1);
         end else if ((state == STROBE) || (state == WAIT)) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept) next_state = STROBE;
         end
         STROBE: begin
            if (cnt == STROBE_END) begin
               if (is_write || (cnt == SAMPLE_AT)) next_state = RESP;
               else                                next_state = WAIT;
            end
         end
         WAIT: begin
            if (cnt == SAMPLE_AT) next_state = RESP;
         end
         RESP: begin
            if (rsp_ready) next_state = GAP;
         end
         GAP: begin
            if (len_left != '0) next_state = STROBE;
            else                next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Output logic: values the registered outputs take at the coming edge.
   always_comb begin
      // Beat parameters come straight from the command on accept, and from
      // the incremented address when a burst starts its next beat.
      beat_write = is_write;
      beat_addr  = addr;
      beat_wdata = wdata;
      if (state == IDLE) begin
         beat_write = cmd_write;
         beat_addr  = cmd_addr;
         beat_wdata = cmd_wdata;
      end else if (state == GAP) begin
         beat_addr = addr + 1'b1;
      end

      nxt_cmd_ready = (next_state == IDLE);
      nxt_dbread    = (next_state == STROBE) && !beat_write;
      nxt_dbwrite   = (next_state == STROBE) && beat_write;
      nxt_eadr      = (next_state == STROBE) ? beat_addr : '0;
      nxt_spy_out   = ((next_state == STROBE) && beat_write) ? beat_wdata : '0;

      nxt_rsp_valid = (next_state == RESP);
      nxt_rsp_write = 1'b0;
      nxt_rsp_last  = 1'b0;
      nxt_rsp_rdata = '0;
      if (sample) begin
         nxt_rsp_write = is_write;
         nxt_rsp_last  = (len_left == '0);
         nxt_rsp_rdata = is_write ? '0 : spy_in;
      end else if (next_state == RESP) begin
         nxt_rsp_write = rsp_write;
         nxt_rsp_last  = rsp_last;
         nxt_rsp_rdata = rsp_rdata;
      end
   end

   // Registered outputs; reset clears the bus and discards any pending response.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cmd_ready <= 1'b0;
         dbread    <= 1'b0;
         dbwrite   <= 1'b0;
         eadr      <= '0;
         spy_out   <= '0;
         rsp_valid <= 1'b0;
         rsp_write <= 1'b0;
         rsp_last  <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         cmd_ready <= nxt_cmd_ready;
         dbread    <= nxt_dbread;
         dbwrite   <= nxt_dbwrite;
         eadr      <= nxt_eadr;
         spy_out   <= nxt_spy_out;
         rsp_valid <= nxt_rsp_valid;
         rsp_write <= nxt_rsp_write;
         rsp_last  <= nxt_rsp_last;
         rsp_rdata <= nxt_rsp_rdata;
      end
   end

endmodule

// File: tb/tb_spy_bus_master.sv
// tb/tb_spy_bus_master.sv - directed vector bench for spy_bus_master
module tb_spy_bus_master;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_write = 1'b0;
   logic [3:0]  cmd_addr = '0;
   logic [15:0] cmd_wdata = '0;
   logic        rsp_ready = 1'b0;
   logic [15:0] spy_in = '0;
   logic        cv0 = 1'b0, cv1 = 1'b0, cv2 = 1'b0;
`ifdef SPY_BURST_EN
   logic [3:0]  cmd_len = '0;
`endif

   logic        cr0, rv0, rw0, rl0, rd0, wr0;
   logic [15:0] rdata0, so0;
   logic [3:0]  ea0;
   logic        cr1, rv1, rw1, rl1, rd1, wr1;
   logic [15:0] rdata1, so1;
   logic [3:0]  ea1;
   logic        cr2, rv2, rw2, rl2, rd2, wr2;
   logic [15:0] rdata2, so2;
   logic [3:0]  ea2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spy_bus_master u0 (
      .clk(clk), .reset_n(reset_n), .cmd_valid(cv0), .cmd_ready(cr0),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
`ifdef SPY_BURST_EN
      .cmd_len(cmd_len),
`endif
      .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_write(rw0), .rsp_last(rl0),
      .rsp_rdata(rdata0), .spy_in(spy_in), .spy_out(so0), .dbread(rd0),
      .dbwrite(wr0), .eadr(ea0));

   spy_bus_master #(.STROBE_LEN(4), .RD_LAT(4)) u1 (
      .clk(clk), .reset_n(reset_n), .cmd_valid(cv1), .cmd_ready(cr1),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
`ifdef SPY_BURST_EN
      .cmd_len(cmd_len),
`endif
      .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_write(rw1), .rsp_last(rl1),
      .rsp_rdata(rdata1), .spy_in(spy_in), .spy_out(so1), .dbread(rd1),
      .dbwrite(wr1), .eadr(ea1));

   spy_bus_master #(.STROBE_LEN(1), .RD_LAT(3)) u2 (
      .clk(clk), .reset_n(reset_n), .cmd_valid(cv2), .cmd_ready(cr2),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
`ifdef SPY_BURST_EN
      .cmd_len(cmd_len),
`endif
      .rsp_valid(rv2), .rsp_ready(rsp_ready), .rsp_write(rw2), .rsp_last(rl2),
      .rsp_rdata(rdata2), .spy_in(spy_in), .spy_out(so2), .dbread(rd2),
      .dbwrite(wr2), .eadr(ea2));

   // {cmd_ready, dbread, dbwrite, eadr, spy_out, rsp_valid, rsp_write, rsp_last, rsp_rdata}
   typedef struct {
      logic        rst;
      logic        cv;
      logic        cw;
      logic [3:0]  ad;
      logic [15:0] wd;
      logic        rr;
      logic [15:0] si;
      logic [41:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [41:0] ex(input logic cr, input logic rd, input logic wr,
                                      input logic [3:0] ea, input logic [15:0] so,
                                      input logic rv, input logic rw, input logic rl,
                                      input logic [15:0] rdat);
      return {cr, rd, wr, ea, so, rv, rw, rl, rdat};
   endfunction

   function automatic void add(input logic rst, input logic cv, input logic cw,
                               input logic [3:0] ad, input logic [15:0] wd,
                               input logic rr, input logic [15:0] si,
                               input logic [41:0] e);
      vec_t v;
      v.rst = rst; v.cv = cv; v.cw = cw; v.ad = ad; v.wd = wd;
      v.rr = rr; v.si = si; v.exp = e;
      tbl.push_back(v);
   endfunction

   task automatic check(input string name, input logic [41:0] act, input logic [41:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic seen_rv;

      // Reset, write addr 3 / data 16'o12, then its ack.
      add(0, 0, 0, 4'd0, 16'h0, 0, 16'h0,    ex(0, 0, 0, 4'd0, 16'h0, 0, 0, 0, 16'h0));
      add(1, 0, 0, 4'd0, 16'h0, 0, 16'h0,    ex(1, 0, 0, 4'd0, 16'h0, 0, 0, 0, 16'h0));
      add(1, 1, 1, 4'd3, 16'o12, 1, 16'h0,   ex(0, 0, 1, 4'd3, 16'o12, 0, 0, 0, 16'h0));
      add(1, 0, 0, 4'd0, 16'h0, 1, 16'h0,    ex(0, 0, 0, 4'd0, 16'h0, 1, 1, 1, 16'h0));
      add(1, 0, 0, 4'd0, 16'h0, 1, 16'h0,    ex(0, 0, 0, 4'd0, 16'h0, 0, 0, 0, 16'h0));
      add(1, 0, 0, 4'd0, 16'h0, 1, 16'h0,    ex(1, 0, 0, 4'd0, 16'h0, 0, 0, 0, 16'h0));
      // Read addr 7 returning beef, then 10 cycles of backpressure with a
      // competing command and changing spy_in.
      add(1, 1, 0, 4'd7, 16'h0, 1, 16'hbeef, ex(0, 1, 0, 4'd7, 16'h0, 0, 0, 0, 16'h0));
      add(1, 0, 0, 4'd0, 16'h0, 1, 16'hbeef, ex(0, 0, 0, 4'd0, 16'h0, 1, 0, 1, 16'hbeef));
      for (int i = 0; i < 10; i++)
         add(1, 1, 1, 4'd5, 16'h5555, 0, 16'h1234, ex(0, 0, 0, 4'd0, 16'h0, 1, 0, 1, 16'hbeef));
      add(1, 0, 0, 4'd0, 16'h0, 1, 16'h0,    ex(0, 0, 0, 4'd0, 16'h0, 0, 0, 0, 16'h0));
      add(1, 0, 0, 4'd0, 16'h0, 1, 16'h0,    ex(1, 0, 0, 4'd0, 16'h0, 0, 0, 0, 16'h0));
      // Read at the top address with all-ones data.
      add(1, 1, 0, 4'd15, 16'h0, 1, 16'h0,   ex(0, 1, 0, 4'd15, 16'h0, 0, 0, 0, 16'h0));
      add(1, 0, 0, 4'd0, 16'h0, 1, 16'hffff, ex(0, 0, 0, 4'd0, 16'h0, 1, 0, 1, 16'hffff));
      add(1, 0, 0, 4'd0, 16'h0, 1, 16'h0,    ex(0, 0, 0, 4'd0, 16'h0, 0, 0, 0, 16'h0));
      add(1, 0, 0, 4'd0, 16'h0, 1, 16'h0,    ex(1, 0, 0, 4'd0, 16'h0, 0, 0, 0, 16'h0));

      #1;
      check("reset_async", {cr0, rd0, wr0, ea0, so0, rv0, rw0, rl0, rdata0}, 42'h0);

      for (int i = 0; i < tbl.size(); i++) begin
         reset_n   = tbl[i].rst;
         cv0       = tbl[i].cv;
         cmd_write = tbl[i].cw;
         cmd_addr  = tbl[i].ad;
         cmd_wdata = tbl[i].wd;
         rsp_ready = tbl[i].rr;
         spy_in    = tbl[i].si;
         tick();
         check($sformatf("vec%0d", i), {cr0, rd0, wr0, ea0, so0, rv0, rw0, rl0, rdata0}, tbl[i].exp);
      end
      cv0 = 1'b0;
      rsp_ready = 1'b1;

`ifdef SPY_BURST_EN
      // Two-beat burst wrapping from address 15 to 0.
      cv0 = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd15; cmd_len = 4'd1; spy_in = 16'haaaa;
      tick();
      cv0 = 1'b0; cmd_len = 4'd0;
      check("burst_b0_strobe", {28'h0, rd0, ea0}, {28'h0, 1'b1, 4'd15});
      tick();
      check("burst_b0_rsp", {24'h0, rv0, rl0, rdata0}, {24'h0, 1'b1, 1'b0, 16'haaaa});
      spy_in = 16'h5555;
      tick();
      tick();
      check("burst_b1_strobe", {28'h0, rd0, ea0}, {28'h0, 1'b1, 4'd0});
      tick();
      check("burst_b1_rsp", {24'h0, rv0, rl0, rdata0}, {24'h0, 1'b1, 1'b1, 16'h5555});
      tick();
      tick();
      check("burst_idle", {41'h0, cr0}, 42'h1);
`endif

      // Reset in the middle of a long strobe.
      cv1 = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd9;
      tick();
      cv1 = 1'b0;
      check("long_strobe_start", {37'h0, rd1, ea1}, {37'h0, 1'b1, 4'd9});
      tick();
      check("long_strobe_held", {37'h0, rd1, ea1}, {37'h0, 1'b1, 4'd9});
      #2 reset_n = 1'b0;
      #1;
      check("reset_mid_strobe", {36'h0, cr1, rd1, ea1}, 42'h0);
      tick();
      tick();
      reset_n = 1'b1;
      seen_rv = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (rv1) seen_rv = 1'b1;
      end
      check("no_rsp_after_reset", {41'h0, seen_rv}, 42'h0);
      check("ready_after_reset", {41'h0, cr1}, 42'h1);

      // RD_LAT=3: sample edge ends cycle E+3, rsp_valid at E+4.
      cv2 = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd2; spy_in = 16'h0;
      tick();
      cv2 = 1'b0; spy_in = 16'h1111;
      check("lat3_strobe", {37'h0, rd2, ea2}, {37'h0, 1'b1, 4'd2});
      tick();
      spy_in = 16'h2222;
      check("lat3_e2", {40'h0, rv2, rd2}, 42'h0);
      tick();
      spy_in = 16'h3333;
      check("lat3_e3", {40'h0, rv2, rd2}, 42'h0);
      tick();
      spy_in = 16'h4444;
      check("lat3_rsp", {25'h0, rv2, rdata2}, {25'h0, 1'b1, 16'h3333});
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
